// File: rtl/cnn_inst_sequencer_if.sv
// ----------------------------------------------------------------------------
// cnn_inst_sequencer_if
// Purpose : groups the host instruction port and the parser issue port of the
//           CNN instruction sequencer into one bundle.
// Signals :
//   cnn_inst       host instruction / command word
//   cnn_inst_en    one-cycle strobe qualifying cnn_inst
//   parser_inst    instruction presented to the parser
//   parser_inst_en one-cycle issue strobe
//   parser_ready   parser idle (1) / executing (0)
// Modports:
//   master : the sequencer (consumes host words, drives the parser)
//   slave  : the environment (host + parser side)
// ----------------------------------------------------------------------------
interface cnn_inst_sequencer_if #(
  parameter int INST_W = 128
) ();
  logic [INST_W-1:0] cnn_inst;
  logic              cnn_inst_en;
  logic [INST_W-1:0] parser_inst;
  logic              parser_inst_en;
  logic              parser_ready;

  modport master (
    input  cnn_inst,
    input  cnn_inst_en,
    input  parser_ready,
    output parser_inst,
    output parser_inst_en
  );

  modport slave (
    output cnn_inst,
    output cnn_inst_en,
    output parser_ready,
    input  parser_inst,
    input  parser_inst_en
  );
endinterface

// File: rtl/cnn_inst_sequencer.sv
// ----------------------------------------------------------------------------
// cnn_inst_sequencer
// Purpose : stores a CNN program written by the host and issues it one
//           instruction at a time to the instruction parser, waiting for the
//           parser's ready to fall and rise again between issues. Supports
//           repeat runs, a zero-work timeout, overflow detection and
//           issue/completion counters.
// Ports   :
//   clk, rst      clock, synchronous active-high reset
//   bus (master)  host word port + parser issue port
//   busy          program running
//   done          one-cycle pulse when the final repeat completes
//   prog_len      number of stored instructions
//   issued_cnt    instructions issued since START (wraps)
//   done_cnt      instructions completed since START (wraps)
//   overflow      sticky: a write was dropped
//   timeout_seen  sticky: an instruction completed by timeout
//   last_cycles, max_cycles  (only with CNN_SEQ_TRACE_EN) issue-to-complete
//                 cycle count of the latest instruction and the maximum
// Optional feature macro: CNN_SEQ_TRACE_EN
// ----------------------------------------------------------------------------
module cnn_inst_sequencer #(
  parameter int INST_W      = 128,
  parameter int DEPTH       = 16,
  parameter int ACK_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  cnn_inst_sequencer_if.master     bus,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   prog_len,
  output logic [CNT_W-1:0]         issued_cnt,
  output logic [CNT_W-1:0]         done_cnt,
  output logic                     overflow,
  output logic                     timeout_seen
`ifdef CNN_SEQ_TRACE_EN
  ,
  output logic [31:0]              last_cycles,
  output logic [31:0]              max_cycles
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AW:0]   DEPTH_L  = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_LOW  = 3'd3,
    S_WAIT_HIGH = 3'd4,
    S_COMPLETE  = 3'd5
  } state_t;

  logic [INST_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [AW:0]       wp_q, wp_d;
  logic [AW-1:0]     rp_q, rp_d;
  logic [7:0]        rep_q, rep_d;
  logic [7:0]        rep_max_q, rep_max_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [CNT_W-1:0]  issued_cnt_q, issued_cnt_d;
  logic [CNT_W-1:0]  done_cnt_q, done_cnt_d;
  logic              overflow_q, overflow_d;
  logic              timeout_seen_q, timeout_seen_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [INST_W-1:0] pinst_q, pinst_d;
  logic              pinst_en_q, pinst_en_d;

  logic              is_cmd, is_clear, is_start, is_write, start_acc;
  logic              mem_we;

  // Host word classification: upper bits all zero marks a command word.
  always_comb begin
    is_cmd    = (bus.cnn_inst[INST_W-1:16] == '0);
    is_clear  = bus.cnn_inst_en && is_cmd && (bus.cnn_inst[7:0] == 8'h01);
    is_start  = bus.cnn_inst_en && is_cmd && (bus.cnn_inst[7:0] == 8'h02);
    is_write  = bus.cnn_inst_en && !is_cmd;
    start_acc = is_start && (state_q == S_IDLE);
  end

  // Next-state logic for the issue FSM, write path and status flags.
  always_comb begin
    state_d        = state_q;
    wp_d           = wp_q;
    rp_d           = rp_q;
    rep_d          = rep_q;
    rep_max_d      = rep_max_q;
    tmo_d          = tmo_q;
    issued_cnt_d   = issued_cnt_q;
    done_cnt_d     = done_cnt_q;
    overflow_d     = overflow_q;
    timeout_seen_d = timeout_seen_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    pinst_d        = pinst_q;
    pinst_en_d     = 1'b0;
    mem_we         = 1'b0;

    if (is_clear) begin
      // CLEAR abandons any in-flight parser op without tracking it.
      wp_d           = '0;
      overflow_d     = 1'b0;
      timeout_seen_d = 1'b0;
      state_d        = S_IDLE;
      busy_d         = 1'b0;
    end else begin
      // Writes land only while idle and while the memory has room.
      if (is_write) begin
        if ((state_q != S_IDLE) || (wp_q == DEPTH_L)) begin
          overflow_d = 1'b1;
        end else begin
          mem_we = 1'b1;
          wp_d   = wp_q + 1'b1;
        end
      end else begin
        mem_we = 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (start_acc) begin
            issued_cnt_d = '0;
            done_cnt_d   = '0;
            rep_d        = 8'd0;
            rep_max_d    = bus.cnn_inst[15:8];
            rp_d         = '0;
            if (wp_q == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = S_FETCH;
              busy_d  = 1'b1;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_FETCH: begin
          // Registered read: data and strobe become visible together in ISSUE.
          pinst_d      = mem[rp_q];
          pinst_en_d   = 1'b1;
          issued_cnt_d = issued_cnt_q + 1'b1;
          state_d      = S_ISSUE;
        end
        S_ISSUE: begin
          tmo_d   = '0;
          state_d = S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          if (!bus.parser_ready) begin
            state_d = S_WAIT_HIGH;
          end else if (tmo_q == TMO_LAST) begin
            // Parser never went busy: treat the instruction as zero-work.
            state_d        = S_COMPLETE;
            timeout_seen_d = 1'b1;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (bus.parser_ready) begin
            state_d = S_COMPLETE;
          end else begin
            state_d = S_WAIT_HIGH;
          end
        end
        S_COMPLETE: begin
          done_cnt_d = done_cnt_q + 1'b1;
          if (({1'b0, rp_q} + 1'b1) < wp_q) begin
            rp_d    = rp_q + 1'b1;
            state_d = S_FETCH;
          end else if (rep_q < rep_max_q) begin
            rep_d   = rep_q + 1'b1;
            rp_d    = '0;
            state_d = S_FETCH;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs of the sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      wp_q           <= '0;
      rp_q           <= '0;
      rep_q          <= 8'd0;
      rep_max_q      <= 8'd0;
      tmo_q          <= '0;
      issued_cnt_q   <= '0;
      done_cnt_q     <= '0;
      overflow_q     <= 1'b0;
      timeout_seen_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pinst_q        <= '0;
      pinst_en_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      wp_q           <= wp_d;
      rp_q           <= rp_d;
      rep_q          <= rep_d;
      rep_max_q      <= rep_max_d;
      tmo_q          <= tmo_d;
      issued_cnt_q   <= issued_cnt_d;
      done_cnt_q     <= done_cnt_d;
      overflow_q     <= overflow_d;
      timeout_seen_q <= timeout_seen_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      pinst_q        <= pinst_d;
      pinst_en_q     <= pinst_en_d;
    end
  end

  // Program memory write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wp_q[AW-1:0]] <= bus.cnn_inst;
    end
  end

  assign bus.parser_inst    = pinst_q;
  assign bus.parser_inst_en = pinst_en_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign prog_len           = wp_q;
  assign issued_cnt         = issued_cnt_q;
  assign done_cnt           = done_cnt_q;
  assign overflow           = overflow_q;
  assign timeout_seen       = timeout_seen_q;

`ifdef CNN_SEQ_TRACE_EN
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] last_q, last_d;
  logic [31:0] max_q, max_d;

  // Cycle count from ISSUE (counted as 1) through COMPLETE inclusive.
  always_comb begin
    cyc_d  = cyc_q;
    last_d = last_q;
    max_d  = max_q;
    if (start_acc) begin
      cyc_d  = 32'd0;
      last_d = 32'd0;
      max_d  = 32'd0;
    end else if (state_q == S_ISSUE) begin
      cyc_d = 32'd1;
    end else if ((state_q == S_WAIT_LOW) || (state_q == S_WAIT_HIGH)) begin
      cyc_d = cyc_q + 32'd1;
    end else if ((state_q == S_COMPLETE) && !is_clear) begin
      last_d = cyc_q + 32'd1;
      if ((cyc_q + 32'd1) > max_q) begin
        max_d = cyc_q + 32'd1;
      end else begin
        max_d = max_q;
      end
    end else begin
      cyc_d = cyc_q;
    end
  end

  // Trace registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q  <= 32'd0;
      last_q <= 32'd0;
      max_q  <= 32'd0;
    end else begin
      cyc_q  <= cyc_d;
      last_q <= last_d;
      max_q  <= max_d;
    end
  end

  assign last_cycles = last_q;
  assign max_cycles  = max_q;
`endif

endmodule

// File: tb/tb_cnn_inst_sequencer.sv
// ----------------------------------------------------------------------------
// tb_cnn_inst_sequencer
// Directed testbench for cnn_inst_sequencer with a small parser model:
//   normal : ready stays high 2 cycles after the issue cycle, low for 10
//   held   : ready never falls (exercises the zero-work timeout)
//   hang   : for one chosen instruction, ready falls and stays low
// Expected values are hand-derived constants.
// ----------------------------------------------------------------------------
module tb_cnn_inst_sequencer;

  localparam int INST_W = 128;
  localparam int DEPTH  = 16;
  localparam int ACKT   = 64;
  localparam int CNT_W  = 16;

  logic               clk;
  logic               rst;
  logic               busy;
  logic               done;
  logic [4:0]         prog_len;
  logic [CNT_W-1:0]   issued_cnt;
  logic [CNT_W-1:0]   done_cnt;
  logic               overflow;
  logic               timeout_seen;
`ifdef CNN_SEQ_TRACE_EN
  logic [31:0]        last_cycles;
  logic [31:0]        max_cycles;
`endif

  cnn_inst_sequencer_if #(.INST_W(INST_W)) bus ();

  cnn_inst_sequencer #(
    .INST_W(INST_W), .DEPTH(DEPTH), .ACK_TIMEOUT(ACKT), .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .prog_len     (prog_len),
    .issued_cnt   (issued_cnt),
    .done_cnt     (done_cnt),
    .overflow     (overflow),
    .timeout_seen (timeout_seen)
`ifdef CNN_SEQ_TRACE_EN
    ,
    .last_cycles  (last_cycles),
    .max_cycles   (max_cycles)
`endif
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [INST_W-1:0] ins_a = 128'h1000_0000_AAAA_0001_0000_0000_0000_00A1;
  logic [INST_W-1:0] ins_b = 128'h2000_0001_BBBB_0002_0000_0000_0000_00B2;
  logic [INST_W-1:0] ins_c = 128'h3000_0002_CCCC_0003_0000_0000_0000_00C3;
  logic [INST_W-1:0] ins_d = 128'h4000_0003_DDDD_0004_0000_0000_0000_00D4;
  logic [INST_W-1:0] cmd_clear = 128'h0000_0000_0000_0000_0000_0000_0000_0001;

  // parser model controls (written only by the main sequence)
  int                pmode    = 0;   // 0 normal, 1 held high
  logic              hang_en  = 1'b0;
  logic [INST_W-1:0] hang_word = '0;

  // observation logs (written only by the monitor)
  logic [INST_W-1:0] issue_log [$];
  int                issue_time [$];
  int                done_pulses = 0;
  int                cyc_n = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // edge counter
  initial begin
    forever begin
      @(posedge clk);
      cyc_n = cyc_n + 1;
    end
  end

  // monitor: sample mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (bus.parser_inst_en) begin
        issue_log.push_back(bus.parser_inst);
        issue_time.push_back(cyc_n);
      end
      if (done) done_pulses = done_pulses + 1;
    end
  end

  // parser model
  initial begin
    bus.parser_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.parser_inst_en) begin
        if (hang_en && (bus.parser_inst == hang_word)) begin
          repeat (3) @(posedge clk);
          #1 bus.parser_ready = 1'b0;
          wait (!hang_en);
          #1 bus.parser_ready = 1'b1;
        end else if (pmode == 0) begin
          repeat (3) @(posedge clk);
          #1 bus.parser_ready = 1'b0;
          repeat (10) @(posedge clk);
          #1 bus.parser_ready = 1'b1;
        end
      end
    end
  end

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run = tests_run + 1;
    if (obs !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // drive one host word for exactly one cycle; returns #1 after the sampling edge
  task automatic send(input logic [INST_W-1:0] w);
    bus.cnn_inst    = w;
    bus.cnn_inst_en = 1'b1;
    @(posedge clk);
    #1;
    bus.cnn_inst_en = 1'b0;
  endtask

  task automatic send_start(input logic [7:0] r);
    logic [INST_W-1:0] w;
    w = '0;
    w[15:8] = r;
    w[7:0]  = 8'h02;
    send(w);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && (n < budget)) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val(tag, {127'd0, busy}, 128'd0);
  endtask

  initial begin
    int base;
    int dbase;
    int t0;
    int ok;

    rst = 1'b1;
    bus.cnn_inst = '0;
    bus.cnn_inst_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // ---- reset state
    check_val("rst_busy",     {127'd0, busy}, 128'd0);
    check_val("rst_done",     {127'd0, done}, 128'd0);
    check_val("rst_prog_len", {123'd0, prog_len}, 128'd0);
    check_val("rst_counts",   {96'd0, issued_cnt, done_cnt}, 128'd0);
    check_val("rst_flags",    {126'd0, overflow, timeout_seen}, 128'd0);
    check_val("rst_pinst",    bus.parser_inst, 128'd0);
    rst = 1'b0;

    // ---- 3 instructions, R = 0, normal parser
    send(ins_a); send(ins_b); send(ins_c);
    check_val("t1_prog_len", {123'd0, prog_len}, 128'd3);
    base  = issue_log.size();
    dbase = done_pulses;
    send_start(8'd0);
    t0 = cyc_n;
    wait_idle("t1_finish", 200);
    idle_cycles(2);
    check_val("t1_issue_cnt", issue_log.size() - base, 3);
    if (issue_log.size() - base == 3) begin
      check_val("t1_inst0", issue_log[base],   ins_a);
      check_val("t1_inst1", issue_log[base+1], ins_b);
      check_val("t1_inst2", issue_log[base+2], ins_c);
      check_val("t1_first_lat", issue_time[base] - t0, 1);
      check_val("t1_gap", issue_time[base+1] - issue_time[base], 16);
    end
    check_val("t1_issued_cnt", {112'd0, issued_cnt}, 128'd3);
    check_val("t1_done_cnt",   {112'd0, done_cnt}, 128'd3);
    check_val("t1_done_pulses", done_pulses - dbase, 1);
    check_val("t1_pinst_hold", bus.parser_inst, ins_c);
    check_val("t1_timeout", {127'd0, timeout_seen}, 128'd0);
`ifdef CNN_SEQ_TRACE_EN
    check_val("t1_last_cycles", {96'd0, last_cycles}, 128'd15);
`endif

    // ---- 2 instructions, R = 2
    send(cmd_clear);
    send(ins_a); send(ins_b);
    base  = issue_log.size();
    dbase = done_pulses;
    send_start(8'd2);
    wait_idle("t2_finish", 400);
    idle_cycles(2);
    check_val("t2_issue_cnt", issue_log.size() - base, 6);
    if (issue_log.size() - base == 6) begin
      for (int i = 0; i < 6; i++) begin
        check_val($sformatf("t2_inst%0d", i), issue_log[base+i], (i % 2 == 0) ? ins_a : ins_b);
      end
    end
    check_val("t2_done_cnt",    {112'd0, done_cnt}, 128'd6);
    check_val("t2_issued_cnt",  {112'd0, issued_cnt}, 128'd6);
    check_val("t2_done_pulses", done_pulses - dbase, 1);

    // ---- ready held high: zero-work timeout
    pmode = 1;
    send(cmd_clear);
    send(ins_a); send(ins_b);
    base  = issue_log.size();
    send_start(8'd0);
    wait_idle("t3_finish", 400);
    check_val("t3_timeout_seen", {127'd0, timeout_seen}, 128'd1);
    check_val("t3_done_cnt", {112'd0, done_cnt}, 128'd2);
    check_val("t3_issue_cnt", issue_log.size() - base, 2);
    if (issue_log.size() - base == 2) begin
      // ISSUE + ACK_TIMEOUT WAIT_LOW cycles + COMPLETE + FETCH
      check_val("t3_gap", issue_time[base+1] - issue_time[base], ACKT + 3);
    end
    pmode = 0;

    // ---- overflow with 17 writes
    send(cmd_clear);
    check_val("t4_clear_timeout", {127'd0, timeout_seen}, 128'd0);
    for (int i = 0; i < 17; i++) send(ins_a + i);
    check_val("t4_prog_len", {123'd0, prog_len}, 128'd16);
    check_val("t4_overflow", {127'd0, overflow}, 128'd1);
    send(cmd_clear);
    check_val("t4_clr_prog_len", {123'd0, prog_len}, 128'd0);
    check_val("t4_clr_overflow", {127'd0, overflow}, 128'd0);

    // ---- CLEAR in WAIT_HIGH on the second instruction
    hang_word = ins_b;
    hang_en   = 1'b1;
    send(ins_a); send(ins_b);
    base  = issue_log.size();
    dbase = done_pulses;
    send_start(8'd0);
    ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      if ((issue_log.size() - base >= 2) && !bus.parser_ready) ok = 1;
      else idle_cycles(1);
    end
    check_val("t5_reach_hang", ok, 1);
    idle_cycles(2);
    send(cmd_clear);
    check_val("t5_busy_fall", {127'd0, busy}, 128'd0);
    idle_cycles(30);
    check_val("t5_no_more_issue", issue_log.size() - base, 2);
    check_val("t5_no_done", done_pulses - dbase, 0);
    hang_en = 1'b0;
    idle_cycles(2);
    check_val("t5_prog_len", {123'd0, prog_len}, 128'd0);
    base = issue_log.size();
    send_start(8'd0);
    check_val("t5_empty_done", {127'd0, done}, 128'd1);
    check_val("t5_empty_busy", {127'd0, busy}, 128'd0);
    check_val("t5_empty_issued", {112'd0, issued_cnt}, 128'd0);
    idle_cycles(1);
    check_val("t5_done_one_cycle", {127'd0, done}, 128'd0);
    idle_cycles(5);
    check_val("t5_empty_no_issue", issue_log.size() - base, 0);

    // ---- START and write while busy
    send(ins_a); send(ins_b); send(ins_c);
    base  = issue_log.size();
    dbase = done_pulses;
    send_start(8'd0);
    idle_cycles(5);
    send_start(8'd5);
    send(ins_d);
    check_val("t6_overflow", {127'd0, overflow}, 128'd1);
    check_val("t6_busy", {127'd0, busy}, 128'd1);
    wait_idle("t6_finish", 300);
    idle_cycles(2);
    check_val("t6_issue_cnt", issue_log.size() - base, 3);
    if (issue_log.size() - base == 3) begin
      check_val("t6_inst0", issue_log[base],   ins_a);
      check_val("t6_inst2", issue_log[base+2], ins_c);
    end
    check_val("t6_done_cnt", {112'd0, done_cnt}, 128'd3);
    check_val("t6_prog_len", {123'd0, prog_len}, 128'd3);
    check_val("t6_done_pulses", done_pulses - dbase, 1);
`ifdef CNN_SEQ_TRACE_EN
    check_val("t6_last_cycles", {96'd0, last_cycles}, 128'd15);
    check_val("t6_max_cycles",  {96'd0, max_cycles}, 128'd15);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
